mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the hart's MMIO bus, downstream of the hart's memory-mapped I/O port. Consumes `mem_write_control_t` store requests, queues bytes in a small FIFO and serialises them as 8N1 frames on `uart_tx`. Produces `memory_mapped_io_write_complete` for back-pressure and `memory_mapped_io_r_data` for status reads.

---
 rtl/mmio_uart_tx_pkg.sv | 48 ++++
 rtl/mmio_uart_tx_if.sv | 20 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 135 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types for the MMIO UART transmitter: hart store-request format,
// register offsets, STATUS layout and TX FSM state encoding.
package mmio_uart_tx_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    write_width_t    width;
    logic            enable;
  } mem_write_control_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam logic [XLEN-1:0] UART_TXDATA_OFFSET = 32'd0;
  localparam logic [XLEN-1:0] UART_STATUS_OFFSET = 32'd4;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  function automatic logic [XLEN-1:0] build_status(input logic [7:0] count,
                                                   input logic       busy,
                                                   input logic       empty,
                                                   input logic       full);
    logic [XLEN-1:0] s;
    s = '0;
    s[STATUS_COUNT_LSB +: 8] = count;
    s[STATUS_BUSY_BIT]       = busy;
    s[STATUS_EMPTY_BIT]      = empty;
    s[STATUS_FULL_BIT]       = full;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Hart-side MMIO bus bundle: store request in, completion and read data out.
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  mem_write_control_t memory_mapped_io_control;
  logic               memory_mapped_io_write_complete;
  logic [XLEN-1:0]    memory_mapped_io_r_data;

  modport master (
    output memory_mapped_io_control,
    input  memory_mapped_io_write_complete,
    input  memory_mapped_io_r_data
  );

  modport slave (
    input  memory_mapped_io_control,
    output memory_mapped_io_write_complete,
    output memory_mapped_io_r_data
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty derive from
// the count only, so a same-cycle pop never frees space for a push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes, STATUS
// reports FIFO occupancy and busy; back-pressure via write_complete.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned     CLKS_PER_BIT = 434,
  parameter int unsigned     FIFO_DEPTH   = 8
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  mmio,
  output logic           uart_tx
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [XLEN-1:0]   TXDATA_ADDR = BASE_ADDR + UART_TXDATA_OFFSET;
  localparam logic [XLEN-1:0]   STATUS_ADDR = BASE_ADDR + UART_STATUS_OFFSET;

  logic             hit;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_rdata;
  logic             busy;
  logic             unused_ctrl;

  uart_tx_state_t   state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  assign hit  = mmio.memory_mapped_io_control.enable &&
                (mmio.memory_mapped_io_control.addr == TXDATA_ADDR);
  assign push = hit && !fifo_full;
  assign busy = (state_q != IDLE);

  assign mmio.memory_mapped_io_write_complete = !(hit && fifo_full);
  assign mmio.memory_mapped_io_r_data =
    (mmio.memory_mapped_io_control.addr == STATUS_ADDR)
      ? build_status(8'(fifo_count), busy, fifo_empty, fifo_full)
      : '0;

  // Only the low byte of a store is transmitted; width is irrelevant here.
  assign unused_ctrl = ^{mmio.memory_mapped_io_control.value[XLEN-1:8],
                         mmio.memory_mapped_io_control.width};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (mmio.memory_mapped_io_control.value[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BAUD_LOAD;
          state_d = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        uart_tx = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        // Chaining straight into START keeps back-to-back frames gapless.
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            baud_d  = BAUD_LOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected bytes, a line
// monitor decodes 8N1 frames cycle-exactly and checks them against the queue.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .mmio    (bus),
    .uart_tx (uart_tx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames = 0;
  bit         mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int start_at(input int i);
    return (starts.size() > i) ? starts[i] : -100000;
  endfunction

  // Line monitor: every cycle of a frame is sampled; a bit must hold steady.
  initial begin : monitor
    logic       first [10];
    bit         ok;
    bit         aborted;
    logic [7:0] b;
    logic [7:0] e;
    int         st;
    forever begin
      @(negedge clock);
      if (!reset && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        st = cyc;
        ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clock);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) first[k / CPB] = uart_tx;
          else if (uart_tx !== first[k / CPB]) ok = 1'b0;
        end
        if (!aborted) begin
          for (int i = 0; i < 8; i++) b[i] = first[i + 1];
          ok = ok && (first[0] === 1'b0) && (first[9] === 1'b1);
          starts.push_back(st);
          frames++;
          check("frame shape", {31'b0, ok}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected frame: got 0x%02h expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            check("frame byte", {24'b0, b}, {24'b0, e});
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_idle(input logic [31:0] a);
    bus.memory_mapped_io_control.enable = 1'b0;
    bus.memory_mapped_io_control.addr   = a;
    bus.memory_mapped_io_control.value  = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] v,
                          output int stall, output int pcyc);
    bus.memory_mapped_io_control.addr   = a;
    bus.memory_mapped_io_control.value  = v;
    bus.memory_mapped_io_control.width  = WIDTH_WORD;
    bus.memory_mapped_io_control.enable = 1'b1;
    stall = 0;
    @(negedge clock);
    while (bus.memory_mapped_io_write_complete !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    pcyc = cyc;
    if (a == BASE) exp_q.push_back(v[7:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("drain in time", {31'b0, (n < 2000)}, 32'd1);
    tick(1);
  endtask

  initial begin : stimulus
    int stall, pc, pc1, s0, highs, f0;
    int stalls [6];

    bus.memory_mapped_io_control = '0;
    bus.memory_mapped_io_control.addr = BASE + 32'd4;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset status", bus.memory_mapped_io_r_data, 32'h0000_0002);
    check("reset write_complete", {31'b0, bus.memory_mapped_io_write_complete}, 32'd1);
    tick(1);

    // Single byte 0xA5: bits 1,0,1,0,0,1,0,1 LSB first
    s0 = starts.size();
    do_store(BASE, 32'h0000_12A5, stall, pc);
    bus_idle(BASE + 32'd4);
    check("single stall", stall, 0);
    drain();
    check("single frames", starts.size() - s0, 1);
    check("single latency", start_at(s0) - pc, 1);

    // Back-pressure: 5 accepted, 6th waits for the first STOP pop (37 stalled cycles)
    s0 = starts.size();
    pc1 = 0;
    for (int i = 0; i < 6; i++) begin
      do_store(BASE, i + 1, stalls[i], pc);
      if (i == 0) pc1 = pc;
    end
    bus_idle(BASE + 32'd4);
    for (int i = 0; i < 5; i++) check("bp stall early", stalls[i], 0);
    check("bp stall 6th", stalls[5], 37);
    drain();
    check("bp frames", starts.size() - s0, 6);
    check("bp latency", start_at(s0) - pc1, 1);
    for (int i = 1; i < 6; i++)
      check("bp gap", start_at(s0 + i) - start_at(s0 + i - 1), FRAME);

    // Status mid-frame: 3 pushes, one already popped -> count 2, busy
    do_store(BASE, 32'h11, stall, pc);
    do_store(BASE, 32'h22, stall, pc);
    do_store(BASE, 32'h33, stall, pc);
    bus_idle(BASE + 32'd4);
    @(negedge clock);
    check("status mid-frame", bus.memory_mapped_io_r_data, 32'h0000_0204);
    drain();

    // Non-hit traffic
    f0 = frames;
    do_store(BASE + 32'd8, 32'h55, stall, pc);
    check("nonhit +8 stall", stall, 0);
    do_store(BASE + 32'd4, 32'h66, stall, pc);
    check("nonhit +4 stall", stall, 0);
    bus_idle(BASE + 32'd4);
    @(negedge clock);
    check("nonhit status", bus.memory_mapped_io_r_data, 32'h0000_0002);
    bus.memory_mapped_io_control.addr = BASE;
    @(negedge clock);
    check("rdata txdata addr", bus.memory_mapped_io_r_data, 32'h0);
    highs = 0;
    repeat (50) begin
      @(negedge clock);
      if (uart_tx === 1'b1) highs++;
    end
    check("nonhit line idle", highs, 50);
    check("nonhit no frames", frames - f0, 0);
    tick(1);

    // Reset during DATA with 2 bytes still queued
    do_store(BASE, 32'h81, stall, pc);
    do_store(BASE, 32'h82, stall, pc);
    do_store(BASE, 32'h83, stall, pc);
    bus_idle(BASE + 32'd4);
    tick(6);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("midreset uart_tx", {31'b0, uart_tx}, 32'd1);
    check("midreset status", bus.memory_mapped_io_r_data, 32'h0000_0002);
    reset = 1'b0;
    f0 = frames;
    highs = 0;
    repeat (100) begin
      @(negedge clock);
      if (uart_tx === 1'b1) highs++;
    end
    check("midreset line idle", highs, 100);
    check("midreset no frames", frames - f0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
